retire_trace_unit: RTL and testbench

Parametrised retire-trace recorder/checker for the ucas-cod CPU test harness. It captures up to NUM_CH register-writeback retire records per cycle into a FIFO and runs in one of two modes. In record mode it streams the records out over a valid/ready port. In compare mode it checks them in order against a golden trace stream and halts on the first mismatch. It sits between the CPU retire bus and either a trace sink or a golden-trace source, replacing per-cycle single-channel trace dumping.

---
 rtl/retire_trace_unit.sv | 235 +++++++++++++++++++++++
 tb/tb_retire_trace_unit.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/retire_trace_unit.sv
// retire_trace_unit: packs up to NUM_CH retire records per cycle into a FIFO, then either
// streams them out (record mode) or checks them in order against a golden trace (compare mode).
module retire_trace_unit #(
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_reset,
    input  logic                  cmp_en,
    input  logic [NUM_CH-1:0]     rt_valid,
    input  logic [NUM_CH-1:0]     rt_rf_en,
    input  logic [32*NUM_CH-1:0]  rt_pc,
    input  logic [5*NUM_CH-1:0]   rt_waddr,
    input  logic [32*NUM_CH-1:0]  rt_wdata,
    input  logic [32*NUM_CH-1:0]  rt_wmask,
    output logic                  rt_ready,
    output logic                  tr_valid,
    input  logic                  tr_ready,
    output logic [31:0]           tr_pc,
    output logic [4:0]            tr_waddr,
    output logic [31:0]           tr_wdata,
    output logic [31:0]           tr_wmask,
    input  logic                  gd_valid,
    output logic                  gd_ready,
    input  logic [31:0]           gd_pc,
    input  logic [4:0]            gd_waddr,
    input  logic [31:0]           gd_wdata,
    input  logic [31:0]           gd_wmask,
    input  logic                  end_req,
    output logic                  done,
    output logic                  overflow,
    output logic                  mismatch,
    output logic [31:0]           mm_pc,
    output logic [4:0]            mm_waddr,
    output logic [31:0]           mm_wdata,
    output logic [31:0]           rec_count,
    output logic [1:0]            dbg_mode
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        MODE_REC  = 2'd0,
        MODE_CMP  = 2'd1,
        MODE_HALT = 2'd2
    } mode_e;

    // Handshakes (tr_* and gd_*): a transfer occurs at a rising edge where valid and ready
    // are both high; valid never depends on ready, and the payload holds while stalled.

    mode_e         mode_q, mode_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   pc_mem_q    [DEPTH];
    logic [31:0]   pc_mem_d    [DEPTH];
    logic [4:0]    waddr_mem_q [DEPTH];
    logic [4:0]    waddr_mem_d [DEPTH];
    logic [31:0]   wdata_mem_q [DEPTH];
    logic [31:0]   wdata_mem_d [DEPTH];
    logic [31:0]   wmask_mem_q [DEPTH];
    logic [31:0]   wmask_mem_d [DEPTH];
    logic          end_q, end_d;
    logic          done_q, done_d;
    logic          overflow_q, overflow_d;
    logic          mismatch_q, mismatch_d;
    logic [31:0]   mm_pc_q, mm_pc_d;
    logic [4:0]    mm_waddr_q, mm_waddr_d;
    logic [31:0]   mm_wdata_q, mm_wdata_d;
    logic [31:0]   rec_count_q, rec_count_d;

    logic          empty;
    logic          full;
    logic [PW-1:0] count;
    logic [PW-1:0] free;
    logic [AW-1:0] head;
    logic [NUM_CH-1:0] qual;
    logic [PW-1:0] n_qual;
    logic          drop;
    logic          do_enq;
    logic [PW-1:0] slot;
    logic          pop;
    logic          rec_inc;
    logic          cmp_fire;
    logic          cmp_diff;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;
    assign free  = full ? '0 : (PW'(DEPTH) - count);
    assign head  = rd_ptr_q[AW-1:0];

    assign rt_ready = (free >= PW'(NUM_CH));
    assign tr_valid = (mode_q == MODE_REC) && !empty;
    assign gd_ready = (mode_q == MODE_CMP) && !empty && !mismatch_q;
    assign tr_pc    = pc_mem_q[head];
    assign tr_waddr = waddr_mem_q[head];
    assign tr_wdata = wdata_mem_q[head];
    assign tr_wmask = wmask_mem_q[head];

    assign cmp_fire = gd_valid && gd_ready;
    // Bits unknown on either side never count as a data difference.
    assign cmp_diff = (pc_mem_q[head] != gd_pc) || (waddr_mem_q[head] != gd_waddr) ||
                      (|((wdata_mem_q[head] ^ gd_wdata) & wmask_mem_q[head] & gd_wmask));

    always_comb begin
        qual   = '0;
        n_qual = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            qual[i] = rt_valid[i] & rt_rf_en[i] & (rt_waddr[5*i +: 5] != 5'd0);
            if (qual[i]) begin
                n_qual = n_qual + PW'(1);
            end
        end
    end

    // Free space is judged before this cycle's pop; a short cycle drops all of its records.
    assign drop   = (n_qual > free);
    assign do_enq = (n_qual != '0) && !drop;

    always_comb begin
        pc_mem_d    = pc_mem_q;
        waddr_mem_d = waddr_mem_q;
        wdata_mem_d = wdata_mem_q;
        wmask_mem_d = wmask_mem_q;
        slot        = wr_ptr_q;
        if (do_enq) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (qual[i]) begin
                    pc_mem_d[slot[AW-1:0]]    = rt_pc[32*i +: 32];
                    waddr_mem_d[slot[AW-1:0]] = rt_waddr[5*i +: 5];
                    wdata_mem_d[slot[AW-1:0]] = rt_wdata[32*i +: 32];
                    wmask_mem_d[slot[AW-1:0]] = rt_wmask[32*i +: 32];
                    slot = slot + PW'(1);
                end
            end
        end
        wr_ptr_d = slot;
    end

    always_comb begin
        pop        = 1'b0;
        rec_inc    = 1'b0;
        mismatch_d = mismatch_q;
        mm_pc_d    = mm_pc_q;
        mm_waddr_d = mm_waddr_q;
        mm_wdata_d = mm_wdata_q;
        overflow_d = overflow_q | drop;
        if (tr_valid && tr_ready) begin
            pop     = 1'b1;
            rec_inc = 1'b1;
        end
        if (cmp_fire) begin
            pop = 1'b1;
            if (cmp_diff) begin
                mismatch_d = 1'b1;
                mm_pc_d    = pc_mem_q[head];
                mm_waddr_d = waddr_mem_q[head];
                mm_wdata_d = wdata_mem_q[head];
            end else begin
                rec_inc = 1'b1;
            end
        end
        rd_ptr_d    = rd_ptr_q + (pop ? PW'(1) : '0);
        rec_count_d = rec_count_q + (rec_inc ? 32'd1 : 32'd0);
        end_d       = end_q | end_req;
        done_d      = done_q | ((end_q | end_req) & empty) | mismatch_d;
    end

    // Mode only follows cmp_en while the FIFO is empty; a mismatch parks it until reset.
    always_comb begin
        mode_d = mode_q;
        case (mode_q)
            MODE_REC: begin
                if (empty && cmp_en) begin
                    mode_d = MODE_CMP;
                end
            end
            MODE_CMP: begin
                if (mismatch_d) begin
                    mode_d = MODE_HALT;
                end else if (empty && !cmp_en) begin
                    mode_d = MODE_REC;
                end
            end
            MODE_HALT: mode_d = MODE_HALT;
            default:   mode_d = MODE_REC;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            mode_q      <= MODE_REC;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            end_q       <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            mismatch_q  <= 1'b0;
            mm_pc_q     <= '0;
            mm_waddr_q  <= '0;
            mm_wdata_q  <= '0;
            rec_count_q <= '0;
        end else begin
            mode_q      <= mode_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            end_q       <= end_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
            mismatch_q  <= mismatch_d;
            mm_pc_q     <= mm_pc_d;
            mm_waddr_q  <= mm_waddr_d;
            mm_wdata_q  <= mm_wdata_d;
            rec_count_q <= rec_count_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        pc_mem_q    <= pc_mem_d;
        waddr_mem_q <= waddr_mem_d;
        wdata_mem_q <= wdata_mem_d;
        wmask_mem_q <= wmask_mem_d;
    end

    assign done      = done_q;
    assign overflow  = overflow_q;
    assign mismatch  = mismatch_q;
    assign mm_pc     = mm_pc_q;
    assign mm_waddr  = mm_waddr_q;
    assign mm_wdata  = mm_wdata_q;
    assign rec_count = rec_count_q;
    assign dbg_mode  = mode_q;

endmodule

// File: tb/tb_retire_trace_unit.sv
// Directed bench for retire_trace_unit: compare-rule vector table plus record-mode,
// fill/overflow, random wrap, compare pass/fail and mid-run reset sequences.
module tb_retire_trace_unit;

    localparam int NUM_CH = 2;
    localparam int DEPTH  = 16;

    logic                  sys_clk;
    logic                  sys_reset;
    logic                  cmp_en;
    logic [NUM_CH-1:0]     rt_valid;
    logic [NUM_CH-1:0]     rt_rf_en;
    logic [32*NUM_CH-1:0]  rt_pc;
    logic [5*NUM_CH-1:0]   rt_waddr;
    logic [32*NUM_CH-1:0]  rt_wdata;
    logic [32*NUM_CH-1:0]  rt_wmask;
    logic                  rt_ready;
    logic                  tr_valid;
    logic                  tr_ready;
    logic [31:0]           tr_pc;
    logic [4:0]            tr_waddr;
    logic [31:0]           tr_wdata;
    logic [31:0]           tr_wmask;
    logic                  gd_valid;
    logic                  gd_ready;
    logic [31:0]           gd_pc;
    logic [4:0]            gd_waddr;
    logic [31:0]           gd_wdata;
    logic [31:0]           gd_wmask;
    logic                  end_req;
    logic                  done;
    logic                  overflow;
    logic                  mismatch;
    logic [31:0]           mm_pc;
    logic [4:0]            mm_waddr;
    logic [31:0]           mm_wdata;
    logic [31:0]           rec_count;
    logic [1:0]            dbg_mode;

    retire_trace_unit #(.NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
        .sys_clk(sys_clk), .sys_reset(sys_reset), .cmp_en(cmp_en),
        .rt_valid(rt_valid), .rt_rf_en(rt_rf_en), .rt_pc(rt_pc), .rt_waddr(rt_waddr),
        .rt_wdata(rt_wdata), .rt_wmask(rt_wmask), .rt_ready(rt_ready),
        .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_pc(tr_pc), .tr_waddr(tr_waddr),
        .tr_wdata(tr_wdata), .tr_wmask(tr_wmask),
        .gd_valid(gd_valid), .gd_ready(gd_ready), .gd_pc(gd_pc), .gd_waddr(gd_waddr),
        .gd_wdata(gd_wdata), .gd_wmask(gd_wmask),
        .end_req(end_req), .done(done), .overflow(overflow), .mismatch(mismatch),
        .mm_pc(mm_pc), .mm_waddr(mm_waddr), .mm_wdata(mm_wdata), .rec_count(rec_count),
        .dbg_mode(dbg_mode)
    );

    // Clock / reset
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] mask;
        logic [31:0] g_pc;
        logic [4:0]  g_rd;
        logic [31:0] g_data;
        logic [31:0] g_mask;
        logic        exp_mm;
    } cvec_t;

    int          n_vec;
    int          n_err;
    int          n_out;
    logic        ovf_exp;
    logic [68:0] exp_q[$];
    logic [31:0] g_pc [100];
    logic [4:0]  g_rd [100];
    logic [31:0] g_data [100];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic clear_inputs();
        rt_valid = '0;
        rt_rf_en = '0;
        rt_pc    = '0;
        rt_waddr = '0;
        rt_wdata = '0;
        rt_wmask = '0;
        gd_valid = 1'b0;
        gd_pc    = '0;
        gd_waddr = '0;
        gd_wdata = '0;
        gd_wmask = '0;
        end_req  = 1'b0;
    endtask

    task automatic set_ch(input int ch, input logic [31:0] pc, input logic [4:0] rd,
                          input logic [31:0] data);
        rt_valid[ch]            = 1'b1;
        rt_rf_en[ch]            = 1'b1;
        rt_pc[32*ch +: 32]      = pc;
        rt_waddr[5*ch +: 5]     = rd;
        rt_wdata[32*ch +: 32]   = data;
        rt_wmask[32*ch +: 32]   = 32'hFFFF_FFFF;
    endtask

    task automatic do_reset();
        clear_inputs();
        sys_reset = 1'b1;
        step();
        sys_reset = 1'b0;
        ovf_exp   = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_tr_valid"}, 32'(tr_valid), 32'd0);
        check({tag, "_gd_ready"}, 32'(gd_ready), 32'd0);
        check({tag, "_rt_ready"}, 32'(rt_ready), 32'd1);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
        check({tag, "_mismatch"}, 32'(mismatch), 32'd0);
        check({tag, "_mm_pc"}, mm_pc, 32'd0);
        check({tag, "_mm_waddr"}, 32'(mm_waddr), 32'd0);
        check({tag, "_mm_wdata"}, mm_wdata, 32'd0);
        check({tag, "_rec_count"}, rec_count, 32'd0);
    endtask

    // Record-mode cycle: check ready/valid against the occupancy model, score the record
    // leaving at the coming edge, then queue (or drop) this cycle's qualified channels.
    task automatic tick();
        int          occ0;
        int          nq;
        logic [68:0] exp;
        occ0 = exp_q.size();
        check("rt_ready", 32'(rt_ready), 32'((DEPTH - occ0) >= NUM_CH));
        check("tr_valid", 32'(tr_valid), 32'(occ0 > 0));
        if (occ0 > 0 && tr_ready) begin
            exp = exp_q.pop_front();
            n_vec++;
            n_out++;
            if ({tr_pc, tr_waddr, tr_wdata} !== exp) begin
                n_err++;
                $display("FAIL tr_record: got %h expected %h", {tr_pc, tr_waddr, tr_wdata}, exp);
            end
        end
        nq = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rt_valid[c] && rt_rf_en[c] && rt_waddr[5*c +: 5] != 5'd0) nq++;
        end
        if (nq > DEPTH - occ0) begin
            ovf_exp = 1'b1;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (rt_valid[c] && rt_rf_en[c] && rt_waddr[5*c +: 5] != 5'd0)
                    exp_q.push_back({rt_pc[32*c +: 32], rt_waddr[5*c +: 5], rt_wdata[32*c +: 32]});
            end
        end
        step();
    endtask

    task automatic drain(input string tag);
        int guard;
        clear_inputs();
        tr_ready = 1'b1;
        guard = 0;
        while (exp_q.size() > 0 && guard < 100) begin
            tick();
            guard++;
        end
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        cvec_t tbl [8];
        n_vec    = 0;
        n_err    = 0;
        n_out    = 0;
        cmp_en   = 1'b0;
        tr_ready = 1'b0;
        sys_reset = 1'b1;

        //            pc      rd  data         mask          g_pc    g_rd g_data       g_mask        mm
        tbl[0] = '{32'h0200, 5'd1, 32'h1234, 32'hFFFF_FFFF, 32'h0200, 5'd1, 32'h1234, 32'hFFFF_FFFF, 1'b0};
        tbl[1] = '{32'h0200, 5'd1, 32'h1234, 32'hFFFF_FFFF, 32'h0204, 5'd1, 32'h1234, 32'hFFFF_FFFF, 1'b1};
        tbl[2] = '{32'h0200, 5'd1, 32'h1234, 32'hFFFF_FFFF, 32'h0200, 5'd2, 32'h1234, 32'hFFFF_FFFF, 1'b1};
        tbl[3] = '{32'h0300, 5'd7, 32'h0001, 32'hFFFF_FFFE, 32'h0300, 5'd7, 32'h0000, 32'hFFFF_FFFF, 1'b0};
        tbl[4] = '{32'h0300, 5'd7, 32'h0001, 32'hFFFF_FFFF, 32'h0300, 5'd7, 32'h0000, 32'hFFFF_FFFE, 1'b0};
        tbl[5] = '{32'h0300, 5'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0300, 5'd7, 32'h0, 32'hFFFF_FFFF, 1'b1};
        tbl[6] = '{32'h0400, 5'd9, 32'h00F0, 32'h0000_000F, 32'h0400, 5'd9, 32'h0000, 32'h0000_00F0, 1'b0};
        tbl[7] = '{32'h0400, 5'd9, 32'h0010, 32'h0000_0030, 32'h0400, 5'd9, 32'h0000, 32'h0000_0010, 1'b1};

        do_reset();
        check_reset_vals("init");

        // Record mode: ch1 with rd=0 is skipped, so exactly two records stream out.
        tr_ready = 1'b1;
        n_out = 0;
        set_ch(0, 32'h100, 5'd3, 32'h11);
        set_ch(1, 32'h104, 5'd0, 32'h99);
        tick();
        check("t1_head_pc", tr_pc, 32'h100);
        check("t1_head_rd", 32'(tr_waddr), 32'd3);
        clear_inputs();
        set_ch(1, 32'h108, 5'd5, 32'h22);
        tick();
        check("t1_second_pc", tr_pc, 32'h108);
        clear_inputs();
        for (int i = 0; i < 3; i++) tick();
        check("t1_out_count", n_out, 32'd2);
        check("t1_rec_count", rec_count, 32'd2);

        // Fill with two records per cycle while stalled; the 9th pair finds no room.
        do_reset();
        tr_ready = 1'b0;
        n_out = 0;
        for (int c = 0; c < 9; c++) begin
            if (c == 7) check("fill_ready_at_14", 32'(rt_ready), 32'd1);
            if (c == 8) check("fill_ready_at_16", 32'(rt_ready), 32'd0);
            if (c == 8) check("fill_no_ovf_yet", 32'(overflow), 32'd0);
            set_ch(0, 32'h1000 + 32'(8*c), 5'(c + 1), $urandom);
            set_ch(1, 32'h1004 + 32'(8*c), 5'(c + 10), $urandom);
            tick();
        end
        check("fill_overflow", 32'(overflow), 32'd1);
        drain("fill");
        check("fill_out_count", n_out, 32'd16);
        check("fill_rec_count", rec_count, 32'd16);

        // Random traffic with random back-pressure: order, loss and pointer wrap.
        do_reset();
        n_out = 0;
        for (int c = 0; c < 1000; c++) begin
            clear_inputs();
            for (int ch = 0; ch < NUM_CH; ch++) begin
                rt_valid[ch]          = 1'($urandom_range(0, 1));
                rt_rf_en[ch]          = ($urandom_range(0, 3) != 0);
                rt_pc[32*ch +: 32]    = 32'h8000_0000 + 32'(8*c + 4*ch);
                rt_waddr[5*ch +: 5]   = 5'($urandom_range(0, 31));
                rt_wdata[32*ch +: 32] = $urandom;
                rt_wmask[32*ch +: 32] = $urandom;
            end
            tr_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        drain("rand");
        check("rand_overflow", 32'(overflow), 32'(ovf_exp));
        check("rand_rec_count", rec_count, n_out);

        // Compare rules, one record per vector.
        tr_ready = 1'b0;
        for (int v = 0; v < 8; v++) begin
            cmp_en = 1'b1;
            do_reset();
            set_ch(0, tbl[v].pc, tbl[v].rd, tbl[v].data);
            rt_wmask[31:0] = tbl[v].mask;
            step();
            clear_inputs();
            check($sformatf("vec%0d_gd_ready", v), 32'(gd_ready), 32'd1);
            check($sformatf("vec%0d_tr_valid", v), 32'(tr_valid), 32'd0);
            gd_valid = 1'b1;
            gd_pc    = tbl[v].g_pc;
            gd_waddr = tbl[v].g_rd;
            gd_wdata = tbl[v].g_data;
            gd_wmask = tbl[v].g_mask;
            step();
            clear_inputs();
            check($sformatf("vec%0d_mismatch", v), 32'(mismatch), 32'(tbl[v].exp_mm));
            check($sformatf("vec%0d_rec_count", v), rec_count, 32'(!tbl[v].exp_mm));
            if (tbl[v].exp_mm) check($sformatf("vec%0d_mm_pc", v), mm_pc, tbl[v].pc);
        end

        // Compare pass: golden differs only in bit 31, which the golden mask hides.
        cmp_en = 1'b1;
        do_reset();
        for (int k = 0; k <= 100; k++) begin
            clear_inputs();
            if (k < 100) begin
                g_pc[k]   = 32'h4000 + 32'(4*k);
                g_rd[k]   = 5'($urandom_range(1, 31));
                g_data[k] = $urandom;
                set_ch(0, g_pc[k], g_rd[k], g_data[k]);
            end
            if (k >= 1) begin
                check("pass_gd_ready", 32'(gd_ready), 32'd1);
                gd_valid = 1'b1;
                gd_pc    = g_pc[k-1];
                gd_waddr = g_rd[k-1];
                gd_wdata = g_data[k-1] ^ 32'h8000_0000;
                gd_wmask = 32'h7FFF_FFFF;
            end
            step();
        end
        clear_inputs();
        check("pass_mismatch", 32'(mismatch), 32'd0);
        check("pass_rec_count", rec_count, 32'd100);
        check("pass_done_before_end", 32'(done), 32'd0);
        end_req = 1'b1;
        step();
        end_req = 1'b0;
        check("pass_done", 32'(done), 32'd1);

        // Compare fail on the fifth record (index 4), then reset with six entries queued.
        do_reset();
        for (int k = 0; k <= 5; k++) begin
            clear_inputs();
            g_pc[k]   = 32'h2000 + 32'(4*k);
            g_rd[k]   = 5'(k + 3);
            g_data[k] = $urandom;
            set_ch(0, g_pc[k], g_rd[k], g_data[k]);
            if (k >= 1) begin
                gd_valid = 1'b1;
                gd_pc    = g_pc[k-1];
                gd_waddr = g_rd[k-1];
                gd_wdata = (k - 1 == 4) ? (g_data[k-1] ^ 32'h1) : g_data[k-1];
                gd_wmask = 32'hFFFF_FFFF;
            end
            step();
        end
        clear_inputs();
        check("fail_mismatch", 32'(mismatch), 32'd1);
        check("fail_mm_pc", mm_pc, g_pc[4]);
        check("fail_mm_waddr", 32'(mm_waddr), 32'(g_rd[4]));
        check("fail_mm_wdata", mm_wdata, g_data[4]);
        check("fail_rec_count", rec_count, 32'd4);
        check("fail_gd_ready", 32'(gd_ready), 32'd0);
        check("fail_done", 32'(done), 32'd1);
        check("fail_mode_halt", 32'(dbg_mode), 32'd2);
        gd_valid = 1'b1;
        gd_pc    = g_pc[5];
        gd_waddr = g_rd[5];
        gd_wdata = g_data[5];
        gd_wmask = 32'hFFFF_FFFF;
        step();
        clear_inputs();
        check("fail_rec_count_held", rec_count, 32'd4);
        for (int k = 0; k < 5; k++) begin
            set_ch(0, 32'h3000 + 32'(4*k), 5'd4, $urandom);
            step();
            clear_inputs();
        end
        check("fail_six_queued_ready", 32'(rt_ready), 32'd1);
        check("fail_tr_valid_halt", 32'(tr_valid), 32'd0);
        cmp_en = 1'b0;
        do_reset();
        check_reset_vals("midrun");
        step();
        check("midrun_tr_valid_after", 32'(tr_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
